// File: rtl/serial_div5_frame_transmitter_pkg.sv
// Shared types and mod-5 arithmetic for the serial divisible-by-5 link.
package serial_div_pkg;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} tx_state_t;

  localparam int DIV_MOD = 5;
  localparam int CHECK_W = 3;

  // Remainder after appending one bit to a number whose remainder is rem.
  function automatic logic [2:0] mod5_step(input logic [2:0] rem, input logic b);
    logic [3:0] t;
    t = {rem, 1'b0} + {3'b000, b};
    return 3'(t % 4'(DIV_MOD));
  endfunction

  // Check code c such that (payload*8 + c) is divisible by 5.
  function automatic logic [2:0] mod5_check(input logic [2:0] rem);
    logic [3:0] t;
    t = {rem, 1'b0};
    return 3'(t % 4'(DIV_MOD));
  endfunction

endpackage

// File: rtl/serial_div5_frame_transmitter_if.sv
// Payload-in / serial-bit-out handshake bundle for the div-by-5 transmitter.
interface serial_div5_frame_transmitter_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_bit;
  logic              out_last;
  logic              out_ready;

  // slave: the transmitter itself; master: whoever feeds words and sinks bits
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_bit, out_last);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_bit, out_last);
endinterface

// File: rtl/serial_div5_frame_transmitter_rem.sv
// Registered running remainder (mod 5) of the bits shifted out so far.
module serial_mod5_remainder
  import serial_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [2:0] rem,
  output logic [2:0] rem_next
);
  assign rem_next = mod5_step(rem, bit_in);

  always_ff @(posedge clk) begin
    if (rst || clr) rem <= 3'd0;
    else if (en)    rem <= rem_next;
  end
endmodule

// File: rtl/serial_div5_frame_transmitter.sv
// Serialises a DATA_W-bit word MSB-first; with DIV5_TX_CHECK_EN defined a
// 3-bit check code is appended so the whole frame is divisible by 5.
module serial_div5_frame_transmitter
  import serial_div_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  serial_div5_frame_transmitter_if.slave  bus
);
  // Widened to 2 bits minimum so the 3-bit check phase fits for tiny DATA_W.
  localparam int CNT_W = ($clog2(DATA_W + 1) < 2) ? 2 : $clog2(DATA_W + 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              in_xfer, out_xfer, last_cnt;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;
  assign last_cnt = (cnt == CNT_W'(1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state != IDLE);

`ifdef DIV5_TX_CHECK_EN
  logic [CHECK_W-1:0] chk;
  logic [2:0]         rem, rem_next;

  serial_mod5_remainder u_rem (
    .clk      (clk),
    .rst      (rst),
    .clr      (in_xfer),
    .en       (out_xfer),
    .bit_in   (bus.out_bit),
    .rem      (rem),
    .rem_next (rem_next)
  );

  always_comb begin
    bus.out_bit  = 1'b0;
    bus.out_last = 1'b0;
    case (state)
      DATA:  bus.out_bit = shreg[DATA_W-1];
      CHECK: begin
        bus.out_bit  = chk[CHECK_W-1];
        bus.out_last = last_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      chk   <= '0;
    end else begin
      case (state)
        IDLE: if (in_xfer) begin
          shreg <= bus.in_data;
          cnt   <= CNT_W'(DATA_W);
          state <= DATA;
        end
        DATA: if (out_xfer) begin
          shreg <= shreg << 1;
          if (last_cnt) begin
            // rem_next already folds in the final payload bit
            chk   <= mod5_check(rem_next);
            cnt   <= CNT_W'(CHECK_W);
            state <= CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CHECK: if (out_xfer) begin
          chk <= chk << 1;
          cnt <= cnt - CNT_W'(1);
          if (last_cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  always_comb begin
    bus.out_bit  = 1'b0;
    bus.out_last = 1'b0;
    if (state == DATA) begin
      bus.out_bit  = shreg[DATA_W-1];
      bus.out_last = last_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_xfer) begin
          shreg <= bus.in_data;
          cnt   <= CNT_W'(DATA_W);
          state <= DATA;
        end
        DATA: if (out_xfer) begin
          shreg <= shreg << 1;
          cnt   <= cnt - CNT_W'(1);
          if (last_cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_serial_div5_frame_transmitter.sv
// Randomised scoreboard bench for serial_div5_frame_transmitter; expectations
// follow DIV5_TX_CHECK_EN the same way the design does.
module tb_serial_div5_frame_transmitter;
  localparam int DATA_W = 8;

  typedef struct packed { logic b; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_div5_frame_transmitter_if #(.DATA_W(DATA_W)) bus();

  serial_div5_frame_transmitter #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int   nxfer = 0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: payload MSB-first, then c = 2*(X mod 5) mod 5 so that X*8+c = 0 mod 5.
  function automatic void push_frame(input int x);
    exp_t e;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      e.b = 1'((x >> i) & 1);
`ifdef DIV5_TX_CHECK_EN
      e.last = 1'b0;
`else
      e.last = (i == 0);
`endif
      q.push_back(e);
    end
`ifdef DIV5_TX_CHECK_EN
    begin
      int c;
      c = (2 * (x % 5)) % 5;
      for (int i = 2; i >= 0; i--) begin
        e.b    = 1'((c >> i) & 1);
        e.last = (i == 0);
        q.push_back(e);
      end
    end
`endif
  endfunction

  // Sink backpressure patterns: 0 always ready, 1 toggling, 2 random.
  initial bus.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       bus.out_ready = ~bus.out_ready;
      2:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard
  logic  prev_rst = 1'b1, prev_stall = 1'b0, prev_last_xfer = 1'b0;
  logic  pb = 1'b0, pl = 1'b0;
  longint acc = 0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc            = 0;
      prev_rst       = 1'b1;
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (prev_rst) begin
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_bit",   32'(bus.out_bit),   32'd0);
        check("reset_out_last",  32'(bus.out_last),  32'd0);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_bit",   32'(bus.out_bit),   32'(pb));
        check("stall_last",  32'(bus.out_last),  32'(pl));
      end
      if (prev_last_xfer) begin
        check("idle_in_ready",  32'(bus.in_ready),  32'd1);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
      if (bus.in_valid && bus.in_ready) push_frame(int'(bus.in_data));
      prev_last_xfer = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        nxfer++;
        if (q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_bit",  32'(bus.out_bit),  32'(e.b));
          check("out_last", 32'(bus.out_last), 32'(e.last));
        end
        acc = acc * 2 + longint'(bus.out_bit);
        if (bus.out_last) begin
`ifdef DIV5_TX_CHECK_EN
          check("frame_mod5", 32'(acc % 5), 32'd0);
`endif
          acc = 0;
          prev_last_xfer = 1'b1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      pb         = bus.out_bit;
      pl         = bus.out_last;
      prev_rst   = 1'b0;
    end
  end

  task automatic send(input logic [DATA_W-1:0] x);
    int n = 0;
    @(posedge clk); #1;
    bus.in_data  = x;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!(bus.in_ready && !rst) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(8'd7);   drain();
    send(8'd255); drain();
    ready_mode = 1;
    send(8'd1);   drain();
    ready_mode = 0;

    // reset while the 4th payload bit is on the wire
    send(8'h55);
    begin
      int s = nxfer;
      int n = 0;
      while (nxfer < s + 3 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check("reset_wait_timeout", 32'd1, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(8'd3);   drain();

    send(8'd2);
    send(8'd4);   drain();
    send(8'd0);   drain();
    send(8'hA5);  drain();

    ready_mode = 2;
    repeat (40) begin
      send(DATA_W'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
